bank_addr_gen: RTL and testbench
================================

# bank_addr_gen

Sequential address generator for the multi-lane NTT datapath. It walks every butterfly of every NTT stage, P butterflies per beat. For each of the 2P coefficient lanes it computes the bank index (BI) and in-bank address (BA) with the digit-sum bank mapping. Its packed BA_bus/BI_bus beats feed the bank-input scatter network directly, and it sits between the NTT controller's start/done handshake and that network.

## Interface
- P, 2: butterflies per beat; power of two, 1 ≤ P ≤ 2^(LOGN-1); lanes N_LANES = 2P.
- LOGN, 8: log2 of polynomial length N.
- MAP, 2: bank-index width; equals log2(2P).
- ADDR_WIDTH, LOGN-MAP: in-bank address width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run a full transform; ignored while busy=1.
- inv  in  1  sampled with accepted start; 0 = forward (Cooley-Tukey order), 1 = inverse (Gentleman-Sande order).
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat when out_valid & out_ready.
- BA_bus  out  2P*ADDR_WIDTH  lane i address at [i*ADDR_WIDTH +: ADDR_WIDTH].
- BI_bus  out  2P*MAP  lane i bank index at [i*MAP +: MAP].
- stage_o  out  clog2(LOGN)  stage number of the current beat.
- last_o  out  1  current beat is the last beat of its stage.
- conflict_o  out  1  sticky bank-conflict flag; present only with BANK_CONFLICT_CHK_EN.

## Operation
- FSM with three states.
  - IDLE: start=1 latches inv, clears the stage counter s and beat counter k, and moves to RUN.
  - RUN: each load enable emits beat (s,k). After the beat with s=LOGN-1 and k=BEATS-1 loads, the FSM moves to DRAIN.
  - DRAIN: when that beat is accepted, done pulses for one cycle and the FSM returns to IDLE.
- Load enable is `!out_valid || out_ready`: the single output register refills in the same cycle a beat is accepted. There are no bubbles under continuous ready.
- BEATS = 2^(LOGN-1)/P beats per stage. k wraps to 0 and s increments when k = BEATS-1 loads. Total beats per run: LOGN*BEATS.
- Half-distance h: forward h = N >> (s+1); inverse h = 1 << s.
- For butterfly j = k*P + p (p = 0..P-1), arithmetic is LOGN-bit unsigned:
  - i0 = (j / h)*2h + (j mod h)
  - i1 = i0 + h
- Lane 2p carries i0 and lane 2p+1 carries i1.
- Mapping per lane index x:
  - BA = x >> MAP.
  - BI = sum of the MAP-bit digits of x, truncated to MAP bits (mod 2^MAP).
- Reset values: busy=0, done=0, out_valid=0, BA_bus=0, BI_bus=0, stage_o=0, last_o=0, conflict_o=0. FSM and counters reset to IDLE/0.
- Reset asserted mid-run aborts immediately. No done pulse is produced and the partial beat is discarded.
- While out_valid=1 and out_ready=0, all outputs hold stable.

## Timing
- Start accepted in cycle T: busy=1 and out_valid=1 with beat (0,0) in T+1.
- Under continuous out_ready, beat n is presented in T+1+n. The final beat is at T+LOGN*BEATS. done pulses in T+LOGN*BEATS+1, and busy falls in the same cycle.
- Each stall cycle delays every later event by one cycle.
- start in the done cycle is ignored. start in the following cycle is accepted.

## Configuration
- BANK_CONFLICT_CHK_EN defined:
  - A beat that loads with any two lanes sharing a BI sets conflict_o in the following cycle.
  - conflict_o stays set until the next accepted start or reset.
- Undefined: the conflict_o port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset/idle: hold rst_n=0 and then release with start=0 -> all outputs 0 indefinitely.
- Forward, defaults, out_ready=1: start at T -> beat 0 at T+1 has lane indices 0,128,1,129, BA_bus lanes {0,32,0,32}, BI_bus lanes {0,2,1,3}. 512 beats are emitted, last_o is high on every 64th beat, and done pulses at T+513.
- Inverse, defaults: first beat has indices 0,1,2,3, BA all 0, BI {0,1,2,3}, stage_o=0. Stage 7 first beat has indices 0,128,1,129.
- Backpressure: drop out_ready for 5 cycles mid-stage 3 -> outputs frozen, no beat skipped or duplicated, done delayed by exactly 5 cycles.
- Conflict (macro on): forward run -> beat 320 (s=5, h=4, indices 0,4,1,5, BI {0,1,1,2}) sets conflict_o the next cycle. The flag stays high through done and clears on the next start.
- Reset mid-run at beat 100 -> out_valid=0 and busy=0 immediately, no done pulse. A subsequent start restarts at beat (0,0).

Source files
------------

// File: rtl/bank_addr_gen.sv
// bank_addr_gen: walks every butterfly of every NTT stage, P butterflies per
// beat, and emits per-lane bank index (digit-sum mapping) and in-bank address.
// Beats leave through one output register with valid/ready flow control.
// Optional feature macro: BANK_CONFLICT_CHK_EN adds the sticky conflict_o flag.
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready.
// While out_valid=1 and out_ready=0 every output holds; out_valid never drops
// without a transfer except on reset.
module bank_addr_gen #(
   parameter int P          = 2,
   parameter int LOGN       = 8,
   parameter int MAP        = 2,
   parameter int ADDR_WIDTH = LOGN - MAP,
   localparam int N_LANES   = 2 * P,
   localparam int SW        = (LOGN > 1) ? $clog2(LOGN) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          inv,
   output logic                          busy,
   output logic                          done,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_LANES*ADDR_WIDTH-1:0] BA_bus,
   output logic [N_LANES*MAP-1:0]        BI_bus,
   output logic [SW-1:0]                 stage_o,
   output logic                          last_o
`ifdef BANK_CONFLICT_CHK_EN
   ,
   output logic                          conflict_o
`endif
);

   localparam int BEATS = (1 << (LOGN - 1)) / P;
   localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LOGP  = $clog2(P);
   localparam int NDIG  = (LOGN + MAP - 1) / MAP;

   localparam logic [KW-1:0]   K_MAX  = KW'(BEATS - 1);
   localparam logic [KW-1:0]   K_ONE  = KW'(1);
   localparam logic [SW-1:0]   S_MAX  = SW'(LOGN - 1);
   localparam logic [SW-1:0]   S_ONE  = SW'(1);
   localparam logic [SW:0]     LH_MAX = (SW + 1)'(LOGN - 1);
   localparam logic [SW:0]     LH_ONE = (SW + 1)'(1);
   localparam logic [LOGN-1:0] ONE    = LOGN'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                        state_q, state_d;
   logic                          inv_q, inv_d;
   logic [SW-1:0]                 s_q, s_d;
   logic [KW-1:0]                 k_q, k_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          out_valid_q, out_valid_d;
   logic [N_LANES*ADDR_WIDTH-1:0] ba_q, ba_d;
   logic [N_LANES*MAP-1:0]        bi_q, bi_d;
   logic [SW-1:0]                 stage_q, stage_d;
   logic                          last_q, last_d;
`ifdef BANK_CONFLICT_CHK_EN
   logic                          conflict_q, conflict_d;
   logic                          beat_dup;
   logic [MAP-1:0]                bi_lane [N_LANES];
`endif

   // beat currently being generated (IDLE generates beat (0,0) for a start)
   logic [SW-1:0]                 sel_s;
   logic [KW-1:0]                 sel_k;
   logic                          sel_inv;
   logic [N_LANES*ADDR_WIDTH-1:0] beat_ba;
   logic [N_LANES*MAP-1:0]        beat_bi;
   logic [SW:0]                   lh, lh1;
   logic [LOGN-1:0]               h, j, i0, x;
   logic [MAP-1:0]                dsum;
   logic                          start_acc, ld, k_end, s_end;

   // select which (stage, beat) feeds the generator
   always_comb begin
      if (state_q == S_IDLE) begin
         sel_s   = '0;
         sel_k   = '0;
         sel_inv = inv;
      end else begin
         sel_s   = s_q;
         sel_k   = k_q;
         sel_inv = inv_q;
      end
   end

   // butterfly index pair per lane, then digit-sum bank mapping
   always_comb begin
      beat_ba = '0;
      beat_bi = '0;
      j       = '0;
      i0      = '0;
      x       = '0;
      dsum    = '0;
`ifdef BANK_CONFLICT_CHK_EN
      beat_dup = 1'b0;
      for (int l = 0; l < N_LANES; l++) bi_lane[l] = '0;
`endif
      // log2 of half-distance: forward N>>(s+1), inverse 1<<s
      lh  = sel_inv ? {1'b0, sel_s} : (LH_MAX - {1'b0, sel_s});
      lh1 = lh + LH_ONE;
      h   = ONE << lh;
      for (int p = 0; p < P; p++) begin
         j  = (LOGN'(sel_k) << LOGP) | LOGN'(p);
         i0 = ((j >> lh) << lh1) | (j & (h - ONE));
         for (int b = 0; b < 2; b++) begin
            x    = (b == 0) ? i0 : (i0 + h);
            dsum = '0;
            for (int d = 0; d < NDIG; d++) dsum = dsum + MAP'(x >> (d * MAP));
            beat_ba[(2*p+b)*ADDR_WIDTH +: ADDR_WIDTH] = x[LOGN-1:MAP];
            beat_bi[(2*p+b)*MAP +: MAP]               = dsum;
`ifdef BANK_CONFLICT_CHK_EN
            bi_lane[2*p+b] = dsum;
`endif
         end
      end
`ifdef BANK_CONFLICT_CHK_EN
      for (int a = 0; a < N_LANES; a++)
         for (int c = a + 1; c < N_LANES; c++)
            if (bi_lane[a] == bi_lane[c]) beat_dup = 1'b1;
`endif
   end

   // next-state: sequencing, output register load and drain
   always_comb begin
      state_d     = state_q;
      inv_d       = inv_q;
      s_d         = s_q;
      k_d         = k_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      ba_d        = ba_q;
      bi_d        = bi_q;
      stage_d     = stage_q;
      last_d      = last_q;
`ifdef BANK_CONFLICT_CHK_EN
      conflict_d  = conflict_q;
`endif
      // start in the done cycle is ignored so done stays a clean boundary
      start_acc = (state_q == S_IDLE) && start && !done_q;
      ld        = start_acc || ((state_q == S_RUN) && (!out_valid_q || out_ready));
      k_end     = (sel_k == K_MAX);
      s_end     = (sel_s == S_MAX);
      if (start_acc) begin
         inv_d = inv;
`ifdef BANK_CONFLICT_CHK_EN
         conflict_d = 1'b0;
`endif
      end
      if (ld) begin
         ba_d        = beat_ba;
         bi_d        = beat_bi;
         stage_d     = sel_s;
         last_d      = k_end;
         out_valid_d = 1'b1;
         busy_d      = 1'b1;
`ifdef BANK_CONFLICT_CHK_EN
         if (beat_dup) conflict_d = 1'b1;
`endif
         if (k_end) begin
            k_d = '0;
            if (s_end) begin
               s_d     = '0;
               state_d = S_DRAIN;
            end else begin
               s_d     = sel_s + S_ONE;
               state_d = S_RUN;
            end
         end else begin
            k_d     = sel_k + K_ONE;
            s_d     = sel_s;
            state_d = S_RUN;
         end
      end else if ((state_q == S_DRAIN) && out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b1;
         state_d     = S_IDLE;
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         inv_q       <= 1'b0;
         s_q         <= '0;
         k_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         ba_q        <= '0;
         bi_q        <= '0;
         stage_q     <= '0;
         last_q      <= 1'b0;
`ifdef BANK_CONFLICT_CHK_EN
         conflict_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         inv_q       <= inv_d;
         s_q         <= s_d;
         k_q         <= k_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         ba_q        <= ba_d;
         bi_q        <= bi_d;
         stage_q     <= stage_d;
         last_q      <= last_d;
`ifdef BANK_CONFLICT_CHK_EN
         conflict_q  <= conflict_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign BA_bus    = ba_q;
   assign BI_bus    = bi_q;
   assign stage_o   = stage_q;
   assign last_o    = last_q;
`ifdef BANK_CONFLICT_CHK_EN
   assign conflict_o = conflict_q;
`endif

endmodule

// File: tb/tb_bank_addr_gen.sv
// Directed bench for bank_addr_gen at default parameters (P=2, LOGN=8).
module tb_bank_addr_gen;

   localparam int P     = 2;
   localparam int LOGN  = 8;
   localparam int MAP   = 2;
   localparam int AW    = LOGN - MAP;
   localparam int NL    = 2 * P;
   localparam int SW    = 3;
   localparam int W     = SW + 1 + NL * MAP + NL * AW;
   localparam int BEATS = 64;
   localparam int TOTAL = LOGN * BEATS;

   logic             clk = 1'b0;
   logic             rst_n, start, inv, out_ready;
   logic             busy, done, out_valid, last_o;
   logic [NL*AW-1:0] ba_bus;
   logic [NL*MAP-1:0] bi_bus;
   logic [SW-1:0]    stage_o;
`ifdef BANK_CONFLICT_CHK_EN
   logic             conflict_o;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int doff;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] cap [TOTAL];

   bank_addr_gen #(.P(P), .LOGN(LOGN), .MAP(MAP), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inv(inv),
      .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
      .BA_bus(ba_bus), .BI_bus(bi_bus), .stage_o(stage_o), .last_o(last_o)
`ifdef BANK_CONFLICT_CHK_EN
      , .conflict_o(conflict_o)
`endif
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] obs_beat();
      return {stage_o, last_o, bi_bus, ba_bus};
   endfunction

   function automatic logic [W-1:0] pk(input int s, input bit l, input logic [7:0] bi, input logic [23:0] ba);
      return {3'(s), l, bi, ba};
   endfunction

   // reference beat: butterfly formula with division/modulo, base-4 digit sum
   function automatic logic [W-1:0] model_beat(input bit inv_v, input int n);
      int s, k, h, jj, xx, sum, t, lane;
      logic [NL*AW-1:0]  ba;
      logic [NL*MAP-1:0] bi;
      s  = n / BEATS;
      k  = n % BEATS;
      h  = inv_v ? (1 << s) : ((1 << LOGN) >> (s + 1));
      ba = '0;
      bi = '0;
      for (int p = 0; p < P; p++) begin
         jj = k * P + p;
         for (int b = 0; b < 2; b++) begin
            lane = 2 * p + b;
            xx   = (jj / h) * 2 * h + (jj % h) + b * h;
            ba[lane*AW +: AW] = AW'(xx / 4);
            sum = 0;
            t   = xx;
            while (t > 0) begin
               sum = sum + (t % 4);
               t   = t / 4;
            end
            bi[lane*MAP +: MAP] = MAP'(sum % 4);
         end
      end
      return {3'(s), (k == BEATS - 1), bi, ba};
   endfunction

   // full transform with optional stall; returns at the negedge done is seen
   task automatic run_xform(input bit inv_v, input int stall_beat, input int stall_len,
                            input int exp_done, input string tag);
      int t0, n, left, done_off;
      bit stalled;
      exp_q.delete();
      for (int i = 0; i < TOTAL; i++) exp_q.push_back(model_beat(inv_v, i));
      start = 1'b1;
      inv   = inv_v;
      out_ready = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      n = 0; left = 0; stalled = 0; done_off = -1;
      for (int c = 0; c < 2000 && done_off < 0; c++) begin
         if (done) begin
            done_off = cyc - t0;
            chk({tag, "_busy_at_done"}, busy, 0);
            chk({tag, "_valid_at_done"}, out_valid, 0);
         end else if (out_valid) begin
            if (n == stall_beat && !stalled) begin
               stalled = 1;
               left    = stall_len;
            end
            out_ready = (left == 0);
            if (left > 0) left--;
            chk({tag, "_busy"}, busy, 1);
            if (exp_q.size() == 0) chk({tag, "_extra_beat"}, n, TOTAL - 1);
            else chk({tag, "_beat"}, obs_beat(), exp_q[0]);
            if (out_ready) begin
               if (n < TOTAL) cap[n] = obs_beat();
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               n++;
            end
         end
         if (done_off < 0) @(negedge clk);
      end
      out_ready = 1'b1;
      chk({tag, "_done_cycle"}, done_off, exp_done);
      chk({tag, "_beat_count"}, n, TOTAL);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; inv = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_bus", {ba_bus, bi_bus, stage_o, last_o, done}, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_outputs", {busy, done, out_valid, ba_bus, bi_bus, stage_o, last_o}, 0);
`ifdef BANK_CONFLICT_CHK_EN
      chk("idle_conflict", conflict_o, 0);
`endif

      // forward run, continuous ready
      run_xform(1'b0, -1, 0, 513, "fwd");
      chk("fwd_beat0",   cap[0],   pk(0, 1'b0, 8'hD8, 24'h800800));
      chk("fwd_beat63",  cap[63],  pk(0, 1'b1, 8'h2D, 24'hFDFFDF));
      chk("fwd_beat320", cap[320], pk(5, 1'b0, 8'h94, 24'h040040));
      chk("fwd_beat511", cap[511], pk(7, 1'b1, 8'h39, 24'hFFFFFF));
`ifdef BANK_CONFLICT_CHK_EN
      chk("conflict_at_done", conflict_o, 1);
`endif
      // start in the done cycle is ignored, the next cycle is accepted
      start = 1'b1;
      @(negedge clk);
      chk("start_in_done_busy", busy, 0);
      chk("start_in_done_valid", out_valid, 0);
      @(negedge clk);
      start = 1'b0;
      chk("start_after_done_busy", busy, 1);
      chk("start_after_done_beat0", obs_beat(), pk(0, 1'b0, 8'hD8, 24'h800800));
`ifdef BANK_CONFLICT_CHK_EN
      chk("conflict_cleared", conflict_o, 0);
`endif
      // reset at beat 100
      repeat (100) @(negedge clk);
      chk("beat100", obs_beat(), model_beat(1'b0, 100));
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {busy, out_valid, done}, 0);

      // inverse run
      run_xform(1'b1, -1, 0, 513, "inv");
      chk("inv_beat0",   cap[0],   pk(0, 1'b0, 8'hE4, 24'h000000));
      chk("inv_beat448", cap[448], pk(7, 1'b0, 8'hD8, 24'h800800));
      @(negedge clk);
      chk("done_one_cycle", done, 0);

      // forward with a 5-cycle stall in stage 3
      run_xform(1'b0, 200, 5, 518, "stall");
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
